lza_share_sched: RTL

- Round-robin scheduler that time-shares one leading-zero/one predictor + carry-select adder instance (the FPU normalisation datapath) between NUM_REQ FP add/sub lanes.
- Registers the granted operands into an issue stage that drives the shared unit, then captures the sum, shift count and shift direction into a tagged response stage with valid/ready backpressure.
- Sits between the FPU alignment stages (requesters) and the normalisation shifter (response consumer).

---
 rtl/lza_share_sched_pkg.sv | 28 ++
 rtl/lza_share_sched_if.sv | 45 ++++
 rtl/lza_share_sched_rr_arbiter.sv | 36 +++
 rtl/lza_share_sched.sv | 97 +++++++++
 4 files changed

// File: rtl/lza_share_sched_pkg.sv
// rtl/lza_share_sched_pkg.sv - shared FPU normalisation constants, response struct and round-robin pick
package lza_share_sched_pkg;

  localparam int LZA_WIDTH   = 32;
  localparam int LZA_SHIFT_W = 5;
  localparam int RR_MAX      = 8;

  typedef struct packed {
    logic [LZA_WIDTH-1:0]   result;
    logic [LZA_SHIFT_W-1:0] shift_bits;
    logic                   shift_right;
  } lza_rsp_t;

  // Returns {found, index}: first set bit of req scanning upward from ptr, wrapping at n.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic [3:0] sel;
    int         k;
    sel = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      k = (int'(ptr) + i) % n;
      if (!sel[3] && (i < n) && req[k[2:0]]) sel = {1'b1, k[2:0]};
    end
    return sel;
  endfunction

endpackage

// File: rtl/lza_share_sched_if.sv
// rtl/lza_share_sched_if.sv - request, shared-unit and response signal bundle
interface lza_share_sched_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int SHIFT_W = $clog2(WIDTH),
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;

  logic [WIDTH-1:0]         lza_a;
  logic [WIDTH-1:0]         lza_b;
  logic                     lza_cin;
  logic [WIDTH-1:0]         lza_result;
  logic [SHIFT_W-1:0]       lza_shift_bits;
  logic                     lza_shift_right;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic [SHIFT_W-1:0]       rsp_shift_bits;
  logic                     rsp_shift_right;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, req_cin,
    input  lza_result, lza_shift_bits, lza_shift_right,
    input  rsp_ready,
    output req_ready, lza_a, lza_b, lza_cin,
    output rsp_valid, rsp_id, rsp_result, rsp_shift_bits, rsp_shift_right, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_cin,
    output lza_result, lza_shift_bits, lza_shift_right,
    output rsp_ready,
    input  req_ready, lza_a, lza_b, lza_cin,
    input  rsp_valid, rsp_id, rsp_result, rsp_shift_bits, rsp_shift_right, busy
  );

endinterface

// File: rtl/lza_share_sched_rr_arbiter.sv
// rtl/lza_share_sched_rr_arbiter.sv - round-robin grant with rotating priority pointer
module lza_share_sched_rr_arbiter
  import lza_share_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_gnt_valid,
  output logic [ID_W-1:0]    o_gnt_idx
);

  logic [ID_W-1:0] r_ptr;
  logic [3:0]      w_sel;
  logic            w_upd;

  assign w_sel       = rr_pick(8'(i_req), 3'(r_ptr), NUM_REQ);
  assign w_upd       = i_en & w_sel[3];
  assign o_gnt_valid = w_upd;
  assign o_gnt_idx   = ID_W'(w_sel[2:0]);
  assign o_grant     = w_upd ? (NUM_REQ'(1) << o_gnt_idx) : '0;

  // Priority moves to the lane just after the one granted; holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_upd) begin
      r_ptr <= (o_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_gnt_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/lza_share_sched.sv
// rtl/lza_share_sched.sv - time-shares one LZA/adder unit between FP add lanes with a 2-stage pipe
module lza_share_sched
  import lza_share_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int SHIFT_W = $clog2(WIDTH),
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  lza_share_sched_if.slave  bus
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;
  logic [ID_W-1:0]  r_s1_id;

  logic             r_s2_valid;
  lza_rsp_t         r_s2_rsp;
  logic [ID_W-1:0]  r_s2_id;

  logic             w_s2_load;
  logic             w_s1_free;
  logic             w_hs;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [NUM_REQ-1:0] w_grant;

  // S2 takes S1 whenever it is empty or being drained; S1 refills in the same cycle.
  assign w_s2_load = r_s1_valid & (~r_s2_valid | bus.rsp_ready);
  assign w_s1_free = ~r_s1_valid | w_s2_load;

  lza_share_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (bus.req_valid),
    .i_en        (w_s1_free & rst_n),
    .o_grant     (w_grant),
    .o_gnt_valid (w_hs),
    .o_gnt_idx   (w_gnt_idx)
  );

  assign bus.req_ready = w_grant;

  // Issue register: captures the granted lane's operands and tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_id    <= '0;
    end else if (w_hs) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= bus.req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
      r_s1_b     <= bus.req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
      r_s1_cin   <= bus.req_cin[w_gnt_idx];
      r_s1_id    <= w_gnt_idx;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  assign bus.lza_a   = r_s1_a;
  assign bus.lza_b   = r_s1_b;
  assign bus.lza_cin = r_s1_cin;

  // Response register: captures the shared unit's outputs with the issuing lane's tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_rsp   <= '0;
      r_s2_id    <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_s2_rsp   <= '{result:      bus.lza_result,
                      shift_bits:  bus.lza_shift_bits,
                      shift_right: bus.lza_shift_right};
      r_s2_id    <= r_s1_id;
    end else if (bus.rsp_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid       = r_s2_valid;
  assign bus.rsp_id          = r_s2_id;
  assign bus.rsp_result      = r_s2_rsp.result;
  assign bus.rsp_shift_bits  = r_s2_rsp.shift_bits;
  assign bus.rsp_shift_right = r_s2_rsp.shift_right;
  assign bus.busy            = r_s1_valid | r_s2_valid;

endmodule
